// File: rtl/sign_apply.sv
// Sign-magnitude to two's-complement converter behind a two-entry elastic buffer.
// Optional sticky negative-zero flag is built only when SIGN_APPLY_ERRFLAG_EN is defined.
//
//  state | meaning
//  ------+--------------------------------------------
//  EMPTY | no sample buffered, out_valid=0
//  ONE   | head holds one sample
//  FULL  | head and tail both hold samples, in_ready=0
module sign_apply #(
    parameter int MAG_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [MAG_W-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W:0]   out_data,
    output logic             neg_zero_err,
    input  logic             clear_err,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t         state, state_nxt;
    logic           push, pop;
    logic           load_head, load_tail, head_from_tail;
    logic [MAG_W:0] conv;
    logic [MAG_W:0] head_q, tail_q;
    logic           in_ready_q, out_valid_q;
    logic [CNT_W-1:0] cnt_q;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Negating a zero magnitude wraps back to zero at MAG_W+1 bits.
    assign conv = in_sign ? (~{1'b0, in_mag} + (MAG_W+1)'(1)) : {1'b0, in_mag};

    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_nxt = FULL;
                    load_tail = 1'b1;
                end else if (!push && pop) begin
                    state_nxt = EMPTY;
                end else if (push && pop) begin
                    load_head = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != FULL);
            out_valid_q <= (state_nxt != EMPTY);
            if (load_head)
                head_q <= conv;
            else if (head_from_tail)
                head_q <= tail_q;
            if (load_tail)
                tail_q <= conv;
            if (pop)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = head_q;
    assign sample_cnt = cnt_q;

`ifdef SIGN_APPLY_ERRFLAG_EN
    logic err_q;

    // A new negative-zero sample takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (push && in_sign && (in_mag == '0))
            err_q <= 1'b1;
        else if (clear_err)
            err_q <= 1'b0;
    end

    assign neg_zero_err = err_q;
`else
    logic unused_clear_err;

    assign unused_clear_err = clear_err;
    assign neg_zero_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sign_apply.sv
// Randomized and directed bench for sign_apply against a queue-based reference model.
// Flag expectations follow SIGN_APPLY_ERRFLAG_EN.
module tb_sign_apply;

    localparam int MAG_W = 16;
    localparam int CNT_W = 8;
`ifdef SIGN_APPLY_ERRFLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_sign;
    logic [MAG_W-1:0] in_mag;
    logic             out_valid, out_ready;
    logic [MAG_W:0]   out_data;
    logic             neg_zero_err, clear_err;
    logic [CNT_W-1:0] sample_cnt;

    always #5 clk = ~clk;

    sign_apply #(.MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mag(in_mag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .neg_zero_err(neg_zero_err), .clear_err(clear_err),
        .sample_cnt(sample_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [MAG_W:0] mq[$];
    int unsigned    m_cnt = 0;
    bit             m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Two's complement of a sign-magnitude value, as modular arithmetic.
    function automatic logic [MAG_W:0] ref_conv(input bit s, input logic [MAG_W-1:0] m);
        longint unsigned modulus = longint'(1) << (MAG_W + 1);
        longint unsigned v;
        v = s ? ((modulus - longint'(m)) % modulus) : longint'(m);
        return v[MAG_W:0];
    endfunction

    // Entry and exit are 1 time unit after a rising edge.
    task automatic cycle(input bit v, input bit s, input logic [MAG_W-1:0] m,
                         input bit ordy, input bit clr);
        bit push, pop;
        in_valid  = v;
        in_sign   = s;
        in_mag    = m;
        out_ready = ordy;
        clear_err = clr;
        #1;
        check("m_out_valid", out_valid, mq.size() > 0);
        check("m_in_ready", in_ready, mq.size() < 2);
        check("m_sample_cnt", sample_cnt, m_cnt);
        check("m_neg_zero_err", neg_zero_err, m_err);
        if (mq.size() > 0)
            check("m_out_data", out_data, mq[0]);
        push = v && (mq.size() < 2);
        pop  = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(mq.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        if (push)
            mq.push_back(ref_conv(s, m));
        if (ERR_EN) begin
            if (push && s && (m == '0))
                m_err = 1'b1;
            else if (clr)
                m_err = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    // Asserts rst between edges and checks outputs before any clock edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_mag    = '0;
        out_ready = 1'b0;
        clear_err = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_neg_zero_err", neg_zero_err, 0);
        mq.delete();
        m_cnt = 0;
        m_err = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAG_W-1:0] rm;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_mag    = '0;
        out_ready = 1'b0;
        clear_err = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        check("init_out_valid", out_valid, 0);
        check("init_in_ready", in_ready, 1);
        check("init_out_data", out_data, 0);
        check("init_sample_cnt", sample_cnt, 0);
        check("init_neg_zero_err", neg_zero_err, 0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic positive sample
        cycle(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
        check("t2_valid", out_valid, 1);
        check("t2_data", out_data, 17'h01234);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t2_cnt", sample_cnt, 1);
        check("t2_empty", out_valid, 0);

        // negative extremes
        cycle(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("t3_neg_max", out_data, 17'h10001);
        cycle(1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        check("t3_neg_one", out_data, 17'h1FFFF);
        idle(2);

        // negative zero and the sticky flag
        cycle(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        check("t4_negzero_data", out_data, 0);
        check("t4_flag_set", neg_zero_err, ERR_EN);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("t4_flag_clr", neg_zero_err, 0);
        cycle(1'b1, 1'b1, 16'h0000, 1'b1, 1'b1);
        check("t4_set_wins", neg_zero_err, ERR_EN);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(2);

        // backpressure: A, B fill the buffer, C waits
        cycle(1'b1, 1'b0, 16'h0AAA, 1'b0, 1'b0);
        check("t5_ready_after_a", in_ready, 1);
        cycle(1'b1, 1'b1, 16'h0BBB, 1'b0, 1'b0);
        check("t5_full_after_b", in_ready, 0);
        check("t5_head_a", out_data, 17'h00AAA);
        cycle(1'b1, 1'b0, 16'h0CCC, 1'b0, 1'b0);
        check("t5_c_refused", in_ready, 0);
        check("t5_a_stable", out_data, 17'h00AAA);
        cycle(1'b1, 1'b0, 16'h0CCC, 1'b1, 1'b0);
        check("t5_head_b", out_data, 17'h1F445);
        cycle(1'b1, 1'b0, 16'h0CCC, 1'b1, 1'b0);
        check("t5_head_c", out_data, 17'h00CCC);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t5_drained", out_valid, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rm = ($urandom_range(0, 7) == 0) ? 16'h0000 : MAG_W'($urandom);
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rm,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        // asynchronous reset with two samples buffered
        idle(3);
        cycle(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0202, 1'b0, 1'b0);
        check("t1_full_before_rst", in_ready, 0);
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t1_no_output", out_valid, 0);

        // continuous stream of 256 samples
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), MAG_W'($urandom), 1'b1, 1'b0);
            check("t6_valid", out_valid, 1);
            check("t6_ready", in_ready, 1);
        end
        check("t6_cnt_max", sample_cnt, 255);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t6_wrap", sample_cnt, 0);
        check("t6_empty", out_valid, 0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
